uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver for the Nexys A7 build. It takes the asynchronous line driven by the host on `UART_TXD_IN` and turns 8N1 frames into bytes. Received bytes are buffered in a small FIFO and presented to the core through a valid/ready handshake. It is the receive-side counterpart of the core's UART transmit path on `UART_RXD_OUT`, and it runs on the 100 MHz board clock.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `FIFO_DEPTH`, 4: receive buffer entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  board clock (CLK100MHZ).
- `reset`  in  1  reset; asynchronous, active-high.
- `rx`  in  1  serial line; idle high; asynchronous to `clk`.
- `data_out`  out  8  FIFO head byte; 8'h00 whenever `data_valid`=0.
- `data_valid`  out  1  FIFO non-empty.
- `data_ready`  in  1  consumer accepts head when `data_valid`&&`data_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte dropped because FIFO full.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Constants:
  - CPB = CLK_FREQ/BAUD, integer truncation (868 at default).
  - HALF = CPB/2 (434).
  - Bit counter width is $clog2(CPB).
- `rx` passes through a 2-flop synchronizer (both flops reset to 1) to give `rx_s`. All decisions use `rx_s` only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rx_s`=0, go to START with cnt=0.
  - START: cnt increments. At cnt==HALF-1:
    - `rx_s`=0: go to DATA with cnt=0 and bit_idx=0.
    - `rx_s`=1: glitch; return to IDLE with no output.
  - DATA: at cnt==CPB-1, shift `rx_s` into the data register LSB-first and set cnt=0. After bit_idx 7 is sampled, go to STOP.
  - STOP: at cnt==CPB-1:
    - `rx_s`=1: push the byte and go to IDLE.
    - `rx_s`=0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This prevents a break or low line from being read as a stream of 0x00 frames.
- FIFO is first-word-fall-through. `data_out` = mem[rd_ptr].
  - Pop when `data_valid`&&`data_ready`.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full/empty are decided from the MSB comparison.
- Push when full:
  - If a pop happens in the same cycle, the push succeeds (count unchanged).
  - Otherwise the byte is dropped and `overrun` pulses for one cycle. Existing contents are untouched.
- Push and pop together when empty: the push lands and the pop is ignored, because `data_valid` was 0.

## Timing
- Reset values:
  - FSM state IDLE; cnt=0; bit_idx=0.
  - Synchronizer flops = 1.
  - FIFO empty.
  - `data_valid`=0, `data_out`=8'h00, `frame_err`=0, `overrun`=0, `busy`=0.
- Reset mid-frame aborts immediately. The partial byte is lost and the FIFO is emptied.
- Latency: `data_valid` rises 3+HALF+9·CPB+1 cycles (±2) after the falling start edge on `rx`. At default settings that is 8250±2.
- `frame_err` and `overrun` assert in the cycle after the STOP sample and last exactly one cycle.
- A pop takes effect at the clock edge. The new head is visible on `data_out` in the following cycle.
- Back-to-back frames are accepted because STOP returns to IDLE mid-stop-bit. A start edge arriving ≥HALF cycles later is detected.

## Structure
- `uart_pkg` holds:
  - The FSM state enum (`rx_state_t`).
  - A `clks_per_bit(clk, baud)` function.
  - The 8N1 frame constants (DATA_BITS=8).
- A future `uart_tx` reuses this package.
- One sub-module: `sync_fifo`, parameterised by WIDTH and DEPTH. It holds the FWFT buffer and full/empty/overrun logic.
- The synchronizer and FSM stay in `uart_rx`.

## Test plan
- Reset, then send 0x55 at 115200 → `data_valid` rises 8250±2 cycles after the start edge; `data_out`=0x55; `busy` returns to 0.
- Send 0xA3, 0x00, 0xFF back-to-back with `data_ready`=0 → all three are buffered; draining with `data_ready`=1 yields A3, 00, FF in order, one per cycle.
- Send 5 bytes with `data_ready`=0 at depth 4 → `overrun` pulses once on the 5th byte; the FIFO holds bytes 1-4 unchanged.
- Send a 0x3C frame with the stop bit forced low, and keep the line low for 3 bit times → exactly one `frame_err` pulse, no push, no further frames until the line goes high; a following valid 0x3C is received.
- Drive a 200-cycle low glitch on an idle line → no push, no `frame_err`; the FSM returns to IDLE by cycle HALF+3.
- Assert `reset` during DATA bit 4 → all outputs take their reset values asynchronously; the next complete frame (0x81) is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive and transmit paths.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through receive buffer with drop-on-full overrun pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = !empty && pop_ready;
    // A pop in the same cycle frees the slot the push is about to fill.
    assign do_push = push && (!full || do_pop);

    assign valid = !empty;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: line synchronizer, mid-bit sampling FSM, FWFT byte buffer.
//   state     | meaning
//   IDLE      | line high, waiting for a falling edge
//   START     | half-bit wait, confirm start bit still low
//   DATA      | sample 8 data bits at one-bit spacing, LSB first
//   STOP      | sample stop bit; push byte or flag framing error
//   WAIT_IDLE | line held low after a bad frame; wait for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push;
    logic                 ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            frame_err <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BW'(1);
                    if (bit_idx_q == LAST_BIT) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                // Leaving mid-stop-bit gives half a bit of slack for the next start edge.
                if (cnt_q == CPB_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg_q),
        .pop_ready (data_ready),
        .head      (data_out),
        .valid     (data_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx against a queue-based byte model.
module tb_uart_rx;

    localparam int CLK_FREQ = 3_686_400;
    localparam int BAUD     = 115_200;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int LAT      = 3 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int rise_cyc = -1;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];
    int exp_ovr = 0;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (data_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = data_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Caller is at a negedge; rx is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr++;
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", 32'(data_valid), 32'd1);
            chk("drain_data", 32'(data_out), 32'(exp_q[i]));
            data_ready = 1'b1;
            @(negedge clk);
        end
        data_ready = 1'b0;
        exp_q.delete();
        chk("drain_empty", 32'(data_valid), 32'd0);
        chk("empty_data_zero", 32'(data_out), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int t0;
        int lat;
        int n;
        int ovr0;
        int ferr0;
        logic [7:0] seq3 [3];

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single 0x55 frame, latency from start edge
        rise_cyc = -1;
        t0 = cyc;
        model_frame(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        lat = rise_cyc - t0;
        chk("latency_window", 32'(lat >= LAT - 2 && lat <= LAT + 2), 32'd1);
        chk("busy_after_frame", 32'(busy), 32'd0);
        drain();

        // back-to-back A3, 00, FF buffered with ready low
        seq3[0] = 8'hA3; seq3[1] = 8'h00; seq3[2] = 8'hFF;
        ovr0 = ovr_cnt;
        for (int i = 0; i < 3; i++) begin
            model_frame(seq3[i]);
            send_frame(seq3[i], 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("b2b_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
        drain();

        // five bytes into a depth-4 buffer
        ovr0 = ovr_cnt;
        exp_ovr = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            model_frame(b);
            send_frame(b, 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("overrun_once", 32'(ovr_cnt - ovr0), 32'(exp_ovr));
        chk("overrun_model_one", 32'(exp_ovr), 32'd1);
        drain();

        // randomized bursts of random length
        for (int r = 0; r < 4; r++) begin
            ovr0 = ovr_cnt;
            exp_ovr = 0;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                model_frame(b);
                send_frame(b, 1'b1);
            end
            repeat (4) @(negedge clk);
            chk("rand_overrun", 32'(ovr_cnt - ovr0), 32'(exp_ovr));
            drain();
        end

        // stop bit low, line held low 3 more bit times
        ferr0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        chk("ferr_one_pulse", 32'(ferr_cnt - ferr0), 32'd1);
        chk("ferr_no_push", 32'(data_valid), 32'd0);
        chk("ferr_busy_low_line", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        chk("ferr_back_idle", 32'(busy), 32'd0);
        model_frame(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        chk("ferr_count_stable", 32'(ferr_cnt - ferr0), 32'd1);
        drain();

        // short low glitch on an idle line
        ferr0 = ferr_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd1);
        repeat (HALF / 2 - 5) @(negedge clk);
        rx = 1'b1;
        repeat (HALF + 3 - HALF / 2) @(negedge clk);
        chk("glitch_idle", 32'(busy), 32'd0);
        repeat (CPB) @(negedge clk);
        chk("glitch_no_push", 32'(data_valid), 32'd0);
        chk("glitch_no_ferr", 32'(ferr_cnt - ferr0), 32'd0);

        // reset during data bit 4 with a byte already buffered
        b = 8'($urandom);
        model_frame(b);
        send_frame(b, 1'b1);
        repeat (4) @(negedge clk);
        chk("pre_reset_valid", 32'(data_valid), 32'd1);
        b = 8'hC6;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (HALF) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(data_valid), 32'd0);
        chk("async_rst_data", 32'(data_out), 32'd0);
        chk("async_rst_ferr", 32'(frame_err), 32'd0);
        chk("async_rst_ovr", 32'(overrun), 32'd0);
        exp_q.delete();
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        model_frame(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
